// File: rtl/decode_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// decode_hazard_ctrl_if
//   Bundles the decode-side request, writeback retire, fence request and the
//   controller's responses into one port.
//   master : the decode/writeback side. It drives dec_*, wb_* and fence_req,
//            and it receives stall, issue, inflight, fence_done and
//            err_underflow.
//   slave  : the hazard controller.
// ---------------------------------------------------------------------------
interface decode_hazard_ctrl_if;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic [4:0] dec_rd;
  logic       dec_wr_enable;
  logic       wb_wr_enable;
  logic [4:0] wb_wr_addr;
  logic       fence_req;
  logic       stall;
  logic       issue;
  logic [2:0] inflight;
  logic       fence_done;
  logic       err_underflow;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wr_enable, wb_wr_enable, wb_wr_addr, fence_req,
    input  stall, issue, inflight, fence_done, err_underflow
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wr_enable, wb_wr_enable, wb_wr_addr, fence_req,
    output stall, issue, inflight, fence_done, err_underflow
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// decode_hazard_ctrl
//   Scoreboard-based issue controller for the decode stage. Every in-flight
//   register write is counted from issue until writeback retire. Decode is
//   stalled on read-after-write hazards, on a full in-flight budget, and
//   while a fence drains the pipeline.
// Ports
//   clk, rst : clock; synchronous active-high reset
//   bus      : decode_hazard_ctrl_if.slave
//              dec_*        instruction currently in decode
//              wb_*         writeback retire of a register write
//              fence_req    drain request (level, sampled in RUN)
//              stall, issue combinational decode gating
//              inflight     registered count of outstanding writes
//              fence_done   one-cycle pulse on the first RUN cycle after a drain
//              err_underflow sticky flag: a retire hit a zero count
// ---------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_hazard_ctrl_if.slave  bus
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t     r_state;
  logic       r_fence_done;
  logic       r_err_underflow;
  logic [2:0] r_inflight;
  // Entry 0 is held at zero so that x0 can be indexed without a special case.
  logic [2:0] r_cnt [0:31];

  logic [2:0] w_rs1_cnt;
  logic [2:0] w_rs2_cnt;
  logic [2:0] w_rd_cnt;
  logic [2:0] w_wb_cnt;
  logic       w_raw;
  logic       w_cap;
  logic       w_stall;
  logic       w_issue;
  logic       w_alloc;
  logic       w_ret;
  logic       w_underflow;
  logic [2:0] w_inflight_nxt;

  assign w_rs1_cnt = r_cnt[bus.dec_rs1];
  assign w_rs2_cnt = r_cnt[bus.dec_rs2];
  assign w_rd_cnt  = r_cnt[bus.dec_rd];
  assign w_wb_cnt  = r_cnt[bus.wb_wr_addr];

  // The hazard uses the registered count only. A retire in the same cycle
  // does not clear it, because the register file has no write-through. This
  // also keeps wb_* off the combinational path to stall.
  assign w_raw = (bus.dec_rs1_used && (bus.dec_rs1 != 5'd0) && (w_rs1_cnt != 3'd0)) ||
                 (bus.dec_rs2_used && (bus.dec_rs2 != 5'd0) && (w_rs2_cnt != 3'd0));

  // Block a writer when the global budget is full, or when its own 3-bit
  // counter would overflow.
  assign w_cap = bus.dec_wr_enable && (bus.dec_rd != 5'd0) &&
                 ((r_inflight == 3'(MAX_INFLIGHT)) || (w_rd_cnt == 3'd7));

  assign w_stall = bus.dec_valid && ((r_state == ST_DRAIN) || w_raw || w_cap);
  assign w_issue = bus.dec_valid && !w_stall;

  assign w_alloc     = w_issue && bus.dec_wr_enable && (bus.dec_rd != 5'd0);
  assign w_ret       = bus.wb_wr_enable && (bus.wb_wr_addr != 5'd0) && (w_wb_cnt != 3'd0);
  assign w_underflow = bus.wb_wr_enable && (bus.wb_wr_addr != 5'd0) && (w_wb_cnt == 3'd0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_alloc, w_ret})
      2'b10:   w_inflight_nxt = r_inflight + 3'd1;
      2'b01:   w_inflight_nxt = r_inflight - 3'd1;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // Control state: RUN/DRAIN sequencing, in-flight total, and the error flag.
  // A drain ends as soon as the next-cycle total is zero, so a DRAIN entered
  // with nothing outstanding lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_fence_done    <= 1'b0;
      r_err_underflow <= 1'b0;
      r_inflight      <= 3'd0;
    end else begin
      r_inflight      <= w_inflight_nxt;
      r_err_underflow <= r_err_underflow || w_underflow;
      r_fence_done    <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.fence_req) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_inflight_nxt == 3'd0) begin
            r_state      <= ST_RUN;
            r_fence_done <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Per-register outstanding-write counters. An allocate and a retire to the
  // same register in the same cycle cancel each other out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= 3'd0;
    end else begin
      r_cnt[0] <= 3'd0;
      for (int i = 1; i < 32; i++) begin
        if (w_alloc && (bus.dec_rd == i[4:0]) &&
            !(w_ret && (bus.wb_wr_addr == i[4:0])))
          r_cnt[i] <= r_cnt[i] + 3'd1;
        else if (w_ret && (bus.wb_wr_addr == i[4:0]) &&
                 !(w_alloc && (bus.dec_rd == i[4:0])))
          r_cnt[i] <= r_cnt[i] - 3'd1;
      end
    end
  end

  assign bus.stall         = w_stall;
  assign bus.issue         = w_issue;
  assign bus.inflight      = r_inflight;
  assign bus.fence_done    = r_fence_done;
  assign bus.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

  logic clk;
  logic rst;

  decode_hazard_ctrl_if bus ();

  decode_hazard_ctrl #(.MAX_INFLIGHT(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       st;
    logic       iss;
    logic [2:0] inf;
    logic       fd;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dec_valid     = 1'b0;
    bus.dec_rs1       = 5'd0;
    bus.dec_rs2       = 5'd0;
    bus.dec_rs1_used  = 1'b0;
    bus.dec_rs2_used  = 1'b0;
    bus.dec_rd        = 5'd0;
    bus.dec_wr_enable = 1'b0;
    bus.wb_wr_enable  = 1'b0;
    bus.wb_wr_addr    = 5'd0;
    bus.fence_req     = 1'b0;
  endtask

  // One clock cycle of stimulus. The expected combinational stall/issue apply
  // to these inputs; inflight/fence_done/err_underflow are the registered
  // values expected during this same cycle.
  task automatic cyc(input string tag, input logic v,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic we,
                     input logic wbe, input logic [4:0] wba, input logic fr,
                     input logic est, input logic eis, input logic [2:0] einf,
                     input logic efd, input logic eer);
    exp_t e;
    @(posedge clk);
    #1;
    bus.dec_valid     = v;
    bus.dec_rs1       = rs1;
    bus.dec_rs1_used  = u1;
    bus.dec_rs2       = rs2;
    bus.dec_rs2_used  = u2;
    bus.dec_rd        = rd;
    bus.dec_wr_enable = we;
    bus.wb_wr_enable  = wbe;
    bus.wb_wr_addr    = wba;
    bus.fence_req     = fr;
    e.tag = tag; e.st = est; e.iss = eis; e.inf = einf; e.fd = efd; e.er = eer;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output monitor: compares on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("%s.stall", e.tag),    32'(bus.stall),         32'(e.st));
        chk($sformatf("%s.issue", e.tag),    32'(bus.issue),         32'(e.iss));
        chk($sformatf("%s.inflight", e.tag), 32'(bus.inflight),      32'(e.inf));
        chk($sformatf("%s.fdone", e.tag),    32'(bus.fence_done),    32'(e.fd));
        chk($sformatf("%s.err", e.tag),      32'(bus.err_underflow), 32'(e.er));
      end
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    //   tag            v rs1 u1 rs2 u2 rd we wbe wba fr | st is inf fd er
    cyc("rst0",         0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // back-to-back RAW on x5
    cyc("raw.wr5",      1, 0, 0, 0, 0,  5, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("raw.rd5a",     1, 5, 1, 0, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 0);
    cyc("raw.rd5wb",    1, 5, 1, 0, 0,  0, 0, 1, 5, 0,   1, 0, 1, 0, 0);
    cyc("raw.rd5go",    1, 5, 1, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    // x0 and unused sources
    cyc("x0.wr",        1, 0, 0, 0, 0,  0, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("x0.rd",        1, 0, 1, 0, 1,  0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("x0.wr5",       1, 0, 0, 0, 0,  5, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("x0.rs2unused", 1, 0, 1, 5, 0,  0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
    cyc("x0.ret5",      0, 0, 0, 0, 0,  0, 0, 1, 5, 0,   0, 0, 1, 0, 0);
    // capacity with MAX_INFLIGHT = 3
    cyc("cap.wr1",      1, 0, 0, 0, 0,  1, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("cap.wr2",      1, 0, 0, 0, 0,  2, 1, 0, 0, 0,   0, 1, 1, 0, 0);
    cyc("cap.wr3",      1, 0, 0, 0, 0,  3, 1, 0, 0, 0,   0, 1, 2, 0, 0);
    cyc("cap.wr4full",  1, 0, 0, 0, 0,  4, 1, 0, 0, 0,   1, 0, 3, 0, 0);
    cyc("cap.wr4ret1",  1, 0, 0, 0, 0,  4, 1, 1, 1, 0,   1, 0, 3, 0, 0);
    cyc("cap.wr4go",    1, 0, 0, 0, 0,  4, 1, 0, 0, 0,   0, 1, 2, 0, 0);
    cyc("cap.ret2",     0, 0, 0, 0, 0,  0, 0, 1, 2, 0,   0, 0, 3, 0, 0);
    cyc("cap.ret3",     0, 0, 0, 0, 0,  0, 0, 1, 3, 0,   0, 0, 2, 0, 0);
    cyc("cap.ret4",     0, 0, 0, 0, 0,  0, 0, 1, 4, 0,   0, 0, 1, 0, 0);
    // same-cycle allocate and retire on x7
    cyc("same.wr7",     1, 0, 0, 0, 0,  7, 1, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("same.wr7ret7", 1, 0, 0, 0, 0,  7, 1, 1, 7, 0,   0, 1, 1, 0, 0);
    cyc("same.rd7",     1, 7, 1, 0, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 0);
    cyc("same.rd7ret",  1, 7, 1, 0, 0,  0, 0, 1, 7, 0,   1, 0, 1, 0, 0);
    cyc("same.rd7go",   1, 7, 1, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    // underflow on x9, then sticky; a retire to x0 is silent
    cyc("unf.ret9",     0, 0, 0, 0, 0,  0, 0, 1, 9, 0,   0, 0, 0, 0, 0);
    cyc("unf.sticky",   0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    cyc("unf.ret0",     0, 0, 0, 0, 0,  0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    // allocate and retire on different registers keep inflight
    cyc("mix.wr8",      1, 0, 0, 0, 0,  8, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    cyc("mix.wr9ret8",  1, 0, 0, 0, 0,  9, 1, 1, 8, 0,   0, 1, 1, 0, 1);
    cyc("mix.ret9",     0, 0, 0, 0, 0,  0, 0, 1, 9, 0,   0, 0, 1, 0, 1);
    cyc("mix.idle",     0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // fence with two writes pending
    cyc("fen.wr10",     1, 0, 0, 0, 0, 10, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    cyc("fen.wr11req",  1, 0, 0, 0, 0, 11, 1, 0, 0, 1,   0, 1, 1, 0, 1);
    cyc("fen.blk",      1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 2, 0, 1);
    cyc("fen.ret10",    1, 0, 0, 0, 0,  0, 0, 1,10, 0,   1, 0, 2, 0, 1);
    cyc("fen.ret11",    1, 0, 0, 0, 0,  0, 0, 1,11, 0,   1, 0, 1, 0, 1);
    cyc("fen.done",     1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 1, 1);
    cyc("fen.run",      1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
    // fence with nothing outstanding: one-cycle DRAIN
    cyc("fz.req",       0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    cyc("fz.drain",     1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 1);
    cyc("fz.done",      1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 1, 1);
    cyc("fz.run",       1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
    // reset in the middle of a drain
    cyc("rst.wr12",     1, 0, 0, 0, 0, 12, 1, 0, 0, 0,   0, 1, 0, 0, 1);
    cyc("rst.req",      0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 1, 0, 1);
    cyc("rst.blk",      1, 0, 0, 0, 0,  0, 0, 0, 0, 0,   1, 0, 1, 0, 1);
    do_reset();
    cyc("rst.rd12",     1,12, 1, 0, 0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
    cyc("rst.idle1",    0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    cyc("rst.idle2",    0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
